// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame parser.
// Optional build macro: FRAME_TIMEOUT_EN (inter-byte timeout).
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        GET_LEN,
        PAYLOAD,
        GET_CK,
        DRAIN
    } state_t;

    localparam logic [7:0] DEF_SOF = 8'h7E;
    localparam int DEF_MAX_LEN = 16;
    localparam int CK_W = 8;
    localparam logic [15:0] DEF_TIMEOUT_CLKS = 16'd43000;

    function automatic logic [CK_W-1:0] ck_fold(
        input logic [CK_W-1:0] ck,
        input logic [7:0] b
    );
        return ck ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / payload-out stream bundle of the frame parser.
// master drives bytes and ready; slave is the parser.
interface uart_frame_parser_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       err_len;
    logic       err_cksum;
    logic       err_overrun;
    logic       err_timeout;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  err_len,
        input  err_cksum,
        input  err_overrun,
        input  err_timeout
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last,
        output err_len,
        output err_cksum,
        output err_overrun,
        output err_timeout
    );

endinterface

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload store: DEPTH x 8 registers, sync write, comb read.
// Contents are don't-care after reset, so no reset on the array.
module frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_LEN,
    parameter int AW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [CK_W-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [CK_W-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LIM = AW'(DEPTH);

    logic [CK_W-1:0] mem [DEPTH];
    logic [IW-1:0]   wi;
    logic [IW-1:0]   ri;
    logic            w_ok;
    logic            r_ok;

    assign wi = waddr[IW-1:0];
    assign ri = raddr[IW-1:0];
    assign w_ok = waddr < LIM;
    assign r_ok = raddr < LIM;

    // write port; out-of-range addresses are ignored
    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            mem[wi] <= wdata;
        end
    end

    assign rdata = r_ok ? mem[ri] : '0;

endmodule

// File: rtl/uart_frame_parser.sv
// SOF/LEN/payload/XOR-checksum framer behind the UART receiver.
// Define FRAME_TIMEOUT_EN to compile in the inter-byte timeout.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter logic [7:0] SOF = DEF_SOF
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
`endif
) (
    input logic clk,
    input logic rst,
    uart_frame_parser_if.slave bus
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    state_t state_q;
    state_t state_n;

    logic [CW-1:0]   len_q;
    logic [CW-1:0]   len_n;
    logic [CW-1:0]   idx_q;
    logic [CW-1:0]   idx_n;
    logic [CW-1:0]   rd_q;
    logic [CW-1:0]   rd_n;
    logic [CK_W-1:0] ck_q;
    logic [CK_W-1:0] ck_n;

    logic       buf_we;
    logic [7:0] buf_rdata;
    logic       last_n;
    logic       to_hit;
    logic       e_len;
    logic       e_ck;
    logic       e_ovr;
    logic       e_to;

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        timed;

    assign timed = (state_q == GET_LEN) ||
                   (state_q == PAYLOAD) ||
                   (state_q == GET_CK);
    assign to_hit = timed &&
                    (to_cnt == TIMEOUT_CLKS - 16'd1);

    // idle-cycle counter; any byte or leaving the frame clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (bus.in_valid || !timed || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (CW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (bus.in_data),
        .raddr (rd_n),
        .rdata (buf_rdata)
    );

    // next-state, datapath updates and error strobes
    always_comb begin
        state_n = state_q;
        len_n   = len_q;
        idx_n   = idx_q;
        rd_n    = rd_q;
        ck_n    = ck_q;
        buf_we  = 1'b0;
        e_len   = 1'b0;
        e_ck    = 1'b0;
        e_ovr   = 1'b0;
        e_to    = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (bus.in_valid && bus.in_data == SOF) begin
                    state_n = GET_LEN;
                end
            end
            GET_LEN: begin
                if (bus.in_valid) begin
                    if (bus.in_data != 8'd0 &&
                        bus.in_data <= MAX_LEN8) begin
                        len_n   = bus.in_data[CW-1:0];
                        ck_n    = bus.in_data;
                        idx_n   = '0;
                        state_n = PAYLOAD;
                    end else begin
                        e_len   = 1'b1;
                        state_n = HUNT;
                    end
                end else if (to_hit) begin
                    e_to    = 1'b1;
                    state_n = HUNT;
                end
            end
            PAYLOAD: begin
                if (bus.in_valid) begin
                    buf_we = 1'b1;
                    ck_n   = ck_fold(ck_q, bus.in_data);
                    idx_n  = idx_q + ONE;
                    if (idx_q == len_q - ONE) begin
                        state_n = GET_CK;
                    end
                end else if (to_hit) begin
                    e_to    = 1'b1;
                    state_n = HUNT;
                end
            end
            GET_CK: begin
                if (bus.in_valid) begin
                    if (bus.in_data == ck_q) begin
                        rd_n    = '0;
                        state_n = DRAIN;
                    end else begin
                        e_ck    = 1'b1;
                        state_n = HUNT;
                    end
                end else if (to_hit) begin
                    e_to    = 1'b1;
                    state_n = HUNT;
                end
            end
            DRAIN: begin
                e_ovr = bus.in_valid;
                if (bus.out_ready) begin
                    if (rd_q == len_q - ONE) begin
                        rd_n    = '0;
                        state_n = HUNT;
                    end else begin
                        rd_n = rd_q + ONE;
                    end
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    assign last_n = (rd_n == len_n - ONE);

    // parser state and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            len_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            ck_q    <= '0;
        end else begin
            state_q <= state_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            rd_q    <= rd_n;
            ck_q    <= ck_n;
        end
    end

    // registered outputs, presented one cycle after the deciding edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_last    <= 1'b0;
            bus.err_len     <= 1'b0;
            bus.err_cksum   <= 1'b0;
            bus.err_overrun <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.out_valid   <= (state_n == DRAIN);
            bus.out_data    <= (state_n == DRAIN) ? buf_rdata : '0;
            bus.out_last    <= (state_n == DRAIN) && last_n;
            bus.err_len     <= e_len;
            bus.err_cksum   <= e_ck;
            bus.err_overrun <= e_ovr;
            bus.err_timeout <= e_to;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser.
// Timeout scenario follows the FRAME_TIMEOUT_EN build macro.
module tb_uart_frame_parser;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_parser_if bus();

    uart_frame_parser #(
        .MAX_LEN (16),
        .SOF     (8'h7E)
`ifdef FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_CLKS (16'(TO))
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail = 0;

    logic [7:0] cap_d [$];
    logic       cap_l [$];
    int vcyc, n_len, n_ck, n_ovr, n_to;

    // observe outputs away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) vcyc++;
            if (bus.out_valid && bus.out_ready) begin
                cap_d.push_back(bus.out_data);
                cap_l.push_back(bus.out_last);
            end
            if (bus.err_len) n_len++;
            if (bus.err_cksum) n_ck++;
            if (bus.err_overrun) n_ovr++;
            if (bus.err_timeout) n_to++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] bs [$]);
        foreach (bs[i]) strobe(bs[i]);
    endtask

    task automatic clear_mon();
        cap_d.delete();
        cap_l.delete();
        vcyc = 0;
        n_len = 0;
        n_ck = 0;
        n_ovr = 0;
        n_to = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        n_tests++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b l=%b d=%h want 0",
                     bus.out_valid, bus.out_last, bus.out_data);
        end
        n_tests++;
        if ({bus.err_len, bus.err_cksum, bus.err_overrun,
             bus.err_timeout} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b%b%b%b want 0000",
                     bus.err_len, bus.err_cksum,
                     bus.err_overrun, bus.err_timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [$];
        exp_d = '{8'h11, 8'h22, 8'h33};
        clear_mon();
        bus.out_ready = 1'b1;
        send('{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i] ||
                bus.out_last !== (i == 2)) begin
                n_fail++;
                $display("FAIL good_b%0d: got v=%b d=%h l=%b want 1 %h %b",
                         i, bus.out_valid, bus.out_data, bus.out_last,
                         exp_d[i], (i == 2));
            end
            tick();
        end
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_end: got v=%b want 0", bus.out_valid);
        end
        n_tests++;
        if (cap_d.size() != 3 || n_len + n_ck + n_ovr + n_to != 0) begin
            n_fail++;
            $display("FAIL good_cnt: got n=%0d errs=%0d want 3 0",
                     cap_d.size(), n_len + n_ck + n_ovr + n_to);
        end
    endtask

    task automatic test_bad_cksum();
        clear_mon();
        bus.out_ready = 1'b1;
        send('{8'h00, 8'hFF, 8'h7E, 8'h02, 8'hAA, 8'h55, 8'h00});
        n_tests++;
        if (bus.err_cksum !== 1'b1) begin
            n_fail++;
            $display("FAIL cksum_pulse: got %b want 1", bus.err_cksum);
        end
        tick();
        n_tests++;
        if (bus.err_cksum !== 1'b0 || n_ck != 1 || vcyc != 0) begin
            n_fail++;
            $display("FAIL cksum_once: got e=%b n=%0d v=%0d want 0 1 0",
                     bus.err_cksum, n_ck, vcyc);
        end
        send('{8'h7E, 8'h01, 8'h5A, 8'h5B});
        tick();
        n_tests++;
        if (cap_d.size() != 1 || cap_d[0] !== 8'h5A ||
            cap_l[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL cksum_next: got n=%0d d=%h want 1 5a",
                     cap_d.size(), cap_d.size() ? cap_d[0] : 8'h00);
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] exp_d [$];
        exp_d = '{8'h01, 8'h02};
        clear_mon();
        bus.out_ready = 1'b1;
        send('{8'h7E, 8'h00});
        n_tests++;
        if (bus.err_len !== 1'b1) begin
            n_fail++;
            $display("FAIL len_zero: got %b want 1", bus.err_len);
        end
        tick();
        send('{8'h7E, 8'h11});
        n_tests++;
        if (bus.err_len !== 1'b1) begin
            n_fail++;
            $display("FAIL len_big: got %b want 1", bus.err_len);
        end
        tick();
        send('{8'h7E, 8'h02, 8'h01, 8'h02, 8'h01});
        tick();
        tick();
        n_tests++;
        if (n_len != 2 || cap_d.size() != 2) begin
            n_fail++;
            $display("FAIL len_cnt: got e=%0d n=%0d want 2 2",
                     n_len, cap_d.size());
        end
        for (int i = 0; i < 2 && i < cap_d.size(); i++) begin
            n_tests++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 1)) begin
                n_fail++;
                $display("FAIL len_b%0d: got %h/%b want %h/%b",
                         i, cap_d[i], cap_l[i], exp_d[i], (i == 1));
            end
        end
    endtask

    task automatic test_stall_overrun();
        logic [7:0] exp_d [$];
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        clear_mon();
        bus.out_ready = 1'b0;
        send('{8'h7E, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00});
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA1 ||
                bus.out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b d=%h l=%b want 1 a1 0",
                         i, bus.out_valid, bus.out_data, bus.out_last);
            end
            tick();
        end
        for (int i = 0; i < 40 && cap_d.size() < 4; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 ||
                bus.out_data !== exp_d[cap_d.size()]) begin
                n_fail++;
                $display("FAIL stall_data: got v=%b d=%h want 1 %h",
                         bus.out_valid, bus.out_data, exp_d[cap_d.size()]);
            end
            bus.out_ready = (i % 2 == 0);
            bus.in_valid = (i == 3);
            bus.in_data = 8'h7E;
            tick();
            bus.in_valid = 1'b0;
        end
        n_tests++;
        if (cap_d.size() != 4 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done: got n=%0d v=%b want 4 0",
                     cap_d.size(), bus.out_valid);
        end
        for (int i = 0; i < cap_d.size() && i < 4; i++) begin
            n_tests++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL stall_b%0d: got %h/%b want %h/%b",
                         i, cap_d[i], cap_l[i], exp_d[i], (i == 3));
            end
        end
        n_tests++;
        if (n_ovr != 1 || n_ck + n_len != 0) begin
            n_fail++;
            $display("FAIL overrun: got ovr=%0d other=%0d want 1 0",
                     n_ovr, n_ck + n_len);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        bus.out_ready = 1'b1;
        send('{8'h7E, 8'h01, 8'h10, 8'h11});
        tick();
        send('{8'h7E, 8'h01, 8'h20, 8'h21});
        tick();
        n_tests++;
        if (cap_d.size() != 2 || vcyc != 2 || n_ovr != 0) begin
            n_fail++;
            $display("FAIL b2b_cnt: got n=%0d v=%0d o=%0d want 2 2 0",
                     cap_d.size(), vcyc, n_ovr);
        end else begin
            n_tests++;
            if (cap_d[0] !== 8'h10 || cap_d[1] !== 8'h20) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h want 10 20",
                         cap_d[0], cap_d[1]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_d [$];
        clear_mon();
        bus.out_ready = 1'b1;
`ifdef FRAME_TIMEOUT_EN
        begin
            int hit;
            hit = 0;
            send('{8'h7E, 8'h04, 8'h11});
            for (int k = 1; k <= TO + 5; k++) begin
                tick();
                if (bus.err_timeout === 1'b1 && hit == 0) hit = k;
            end
            n_tests++;
            if (hit != TO || n_to != 1) begin
                n_fail++;
                $display("FAIL timeout_at: got cyc=%0d n=%0d want %0d 1",
                         hit, n_to, TO);
            end
            exp_d = '{8'hAA, 8'hBB};
            send('{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h13});
        end
`else
        send('{8'h7E, 8'h04, 8'h11});
        repeat (TO + 10) tick();
        n_tests++;
        if (n_to != 0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: got n=%0d e=%b want 0 0",
                     n_to, bus.err_timeout);
        end
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        send('{8'h22, 8'h33, 8'h44, 8'h40});
`endif
        repeat (6) tick();
        n_tests++;
        if (cap_d.size() != exp_d.size() || n_ck + n_len != 0) begin
            n_fail++;
            $display("FAIL timeout_next: got n=%0d e=%0d want %0d 0",
                     cap_d.size(), n_ck + n_len, exp_d.size());
        end
        for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
            n_tests++;
            if (cap_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL timeout_b%0d: got %h want %h",
                         i, cap_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        bus.out_ready = 1'b1;
        send('{8'h7E, 8'h04, 8'h11, 8'h22});
        rst = 1'b1;
        tick();
        n_tests++;
        if ({bus.out_valid, bus.out_last, bus.out_data, bus.err_len,
             bus.err_cksum, bus.err_overrun, bus.err_timeout} !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_payload: got v=%b d=%h want 0",
                     bus.out_valid, bus.out_data);
        end
        rst = 1'b0;
        tick();
        send('{8'h7E, 8'h01, 8'h99, 8'h98});
        tick();
        n_tests++;
        if (cap_d.size() != 1 || n_ck + n_len + n_to != 0) begin
            n_fail++;
            $display("FAIL rst_next: got n=%0d e=%0d want 1 0",
                     cap_d.size(), n_ck + n_len + n_to);
        end else begin
            n_tests++;
            if (cap_d[0] !== 8'h99) begin
                n_fail++;
                $display("FAIL rst_data: got %h want 99", cap_d[0]);
            end
        end
        bus.out_ready = 1'b0;
        send('{8'h7E, 8'h01, 8'h42, 8'h43});
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_drain: got v=%b want 1", bus.out_valid);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_drain: got v=%b d=%h want 0 00",
                     bus.out_valid, bus.out_data);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_cksum();
        test_bad_len();
        test_stall_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream framer sitting directly downstream of the UART receiver: consumes its one-cycle byte strobes, hunts for a start-of-frame byte, collects a length-prefixed payload, and verifies an XOR checksum. Only payloads of verified frames are released, byte by byte, over a valid/ready stream to the order-handling logic. Malformed, corrupted or stalled frames are dropped and flagged.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255)
- SOF, 8'h7E: start-of-frame byte
- TIMEOUT_CLKS, 16'd43000: inter-byte timeout in clk cycles (5 bit-times at 9600 baud)
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- in_valid  input  1  one-cycle strobe, byte available (receiver rdy)
- in_data  input  8  received byte, valid with in_valid
- out_valid  output  1  payload byte available
- out_ready  input  1  consumer accepts byte when out_valid & out_ready
- out_data  output  8  payload byte
- out_last  output  1  final payload byte of frame
- err_len  output  1  one-cycle pulse, LEN byte 0 or > MAX_LEN
- err_cksum  output  1  one-cycle pulse, checksum mismatch
- err_overrun  output  1  one-cycle pulse, byte dropped while draining
- err_timeout  output  1  one-cycle pulse, inter-byte timeout

## Operation
- Frame: SOF, LEN, LEN payload bytes, CK; CK = LEN ^ payload[0] ^ … ^ payload[LEN-1].
- States: HUNT, GET_LEN, PAYLOAD, GET_CK, DRAIN.
- HUNT: in_valid & in_data==SOF → GET_LEN; all other bytes ignored silently.
- GET_LEN: LEN in 1..MAX_LEN → store LEN, ck=LEN, idx=0, PAYLOAD; else err_len, HUNT.
- PAYLOAD: each byte written to buf[idx], ck^=byte, idx++; after byte LEN-1 → GET_CK. SOF inside payload is ordinary data (no escaping).
- GET_CK: byte==ck → DRAIN, rd=0; else err_cksum, HUNT.
- DRAIN: out_valid=1, out_data=buf[rd], out_last=(rd==LEN-1); on handshake rd++; handshake on last → HUNT. in_valid during DRAIN: byte dropped, err_overrun.
- Timeout counter runs in GET_LEN/PAYLOAD/GET_CK, cleared on every in_valid and on entry; reaching TIMEOUT_CLKS-1 → err_timeout, HUNT.
- idx/rd widths: $clog2(MAX_LEN+1); LEN compared at 8 bits.

## Timing
- Reset: state HUNT; out_valid, out_data, out_last, all err_* = 0; counters, ck, buffer index cleared (buffer contents don't-care).
- All outputs registered. Error pulses assert the cycle after the offending in_valid (or timeout terminal count) for exactly one cycle.
- Latency: CK strobe at cycle t → out_valid=1 with buf[0] at t+1. With out_ready held high, LEN bytes in LEN consecutive cycles; HUNT entered the cycle after last handshake; an SOF arriving that same cycle is accepted.
- out_data/out_last stable while out_valid & !out_ready.
- in_valid and timeout terminal count same cycle: byte wins, counter clears, no error.
- Reset mid-frame: immediate return to HUNT, partial frame discarded, no error pulse.

## Configuration
- FRAME_TIMEOUT_EN defined: timeout counter and err_timeout logic compiled in as above.
- Not defined: no counter; err_timeout tied 0; parser waits indefinitely in GET_LEN/PAYLOAD/GET_CK.

## Structure
- Package uart_frame_pkg: state enum typedef, default SOF, default MAX_LEN, checksum width constant.
- Sub-module frame_buf: MAX_LEN×8 register array, one synchronous write port, one combinational read port; parser owns all control.

## Test plan
- Good frame 7E 03 11 22 33 03, out_ready=1 → out_data 11,22,33 on consecutive cycles, out_last with 33, no err_*.
- Leading garbage 00 FF 7E 02 AA 55 00 (correct CK FD) → err_cksum single pulse, out_valid never asserted; next good frame accepted.
- LEN=00 and LEN=11h (MAX_LEN=16) → err_len each, HUNT; following good frame parsed correctly.
- Good frame with out_ready toggling 1/0 → data held during stalls, all bytes delivered in order; byte strobed during DRAIN → err_overrun, output stream unaffected.
- 7E 04 11 then silence → err_timeout exactly TIMEOUT_CLKS cycles after last strobe (macro defined); macro undefined → no error, completing bytes later yields valid output.
- Assert rst during PAYLOAD → all outputs 0 next cycle, state HUNT; subsequent good frame parsed.
